// File: rtl/pwm_top.sv
// pwm_top: 8-bit PWM generator in the standard tile wrapper.
// The duty value, prescale exponent, polarity and alignment mode are copied
// into shadow registers only at a period boundary, or on every clock while
// the block is disabled. Because of this the output cannot glitch when the
// inputs change in the middle of a period.
// The direction register is visible on uo_out[3], so the counter state can
// be observed from outside the block.
module pwm_top (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic [7:0] uo_out
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Live state
    logic [7:0]  cnt,     cnt_nx;
    dir_t        dir,     dir_nx;
    logic [14:0] pcnt,    pcnt_nx;

    // Shadowed configuration
    logic [7:0]  duty_sh, duty_nx;
    logic [3:0]  n_sh,    n_nx;
    logic        inv_sh,  inv_nx;
    logic        mode_sh, mode_nx;

    logic        enable;
    logic [14:0] pmax;
    logic        tick;
    logic        boundary;
    logic        raw;
    logic        pwm;
    logic        strobe;

    // The tile-select input and reserved bit 5 have no function here.
    logic        unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in[5]};

    assign enable = uio_in[7];

    // 2^n_sh - 1, built as a right shift of all ones so n_sh = 15 needs no extra width.
    assign pmax = {15{1'b1}} >> (4'd15 - n_sh);
    assign tick = (pcnt == pmax);

    // The last tick of a period: cnt = 255 in edge mode, or the bottom of the down leg in center mode.
    assign boundary = tick &&
                      (((mode_sh == 1'b0) && (cnt == 8'd255)) ||
                       ((mode_sh == 1'b1) && (dir == DIR_DOWN) && (cnt == 8'd0)));

    // State registers; async reset clears everything, so dir starts up and duty starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 8'd0;
            dir     <= DIR_UP;
            pcnt    <= 15'd0;
            duty_sh <= 8'd0;
            n_sh    <= 4'd0;
            inv_sh  <= 1'b0;
            mode_sh <= 1'b0;
        end else begin
            cnt     <= cnt_nx;
            dir     <= dir_nx;
            pcnt    <= pcnt_nx;
            duty_sh <= duty_nx;
            n_sh    <= n_nx;
            inv_sh  <= inv_nx;
            mode_sh <= mode_nx;
        end
    end

    // Next state for the counters, the direction and the shadow configuration.
    always_comb begin
        cnt_nx  = cnt;
        dir_nx  = dir;
        pcnt_nx = pcnt;
        duty_nx = duty_sh;
        n_nx    = n_sh;
        inv_nx  = inv_sh;
        mode_nx = mode_sh;

        if (!enable) begin
            // While disabled the counters are parked at the start of a period
            // and the shadows follow the inputs, so re-enabling starts a clean period.
            cnt_nx  = 8'd0;
            dir_nx  = DIR_UP;
            pcnt_nx = 15'd0;
            duty_nx = ui_in;
            n_nx    = uio_in[3:0];
            inv_nx  = uio_in[4];
            mode_nx = uio_in[6];
        end else if (tick) begin
            pcnt_nx = 15'd0;
            if (boundary) begin
                cnt_nx  = 8'd0;
                dir_nx  = DIR_UP;
                duty_nx = ui_in;
                n_nx    = uio_in[3:0];
                inv_nx  = uio_in[4];
                mode_nx = uio_in[6];
            end else if (mode_sh == 1'b0) begin
                cnt_nx = cnt + 8'd1;
            end else if (dir == DIR_UP) begin
                // Center mode holds at 255 for one tick while turning round, which gives 512 ticks per period.
                if (cnt == 8'd255) begin
                    dir_nx = DIR_DOWN;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end else begin
                cnt_nx = cnt - 8'd1;
            end
        end else begin
            pcnt_nx = pcnt + 15'd1;
        end
    end

    // Output decode, combinational from the registers and the live enable.
    always_comb begin
        raw    = enable & (cnt < duty_sh);
        pwm    = raw ^ inv_sh;
        strobe = enable & (cnt == 8'd0) & (dir == DIR_UP) & (pcnt == 15'd0);
        uo_out = {cnt[7:4], (dir == DIR_DOWN), strobe, ~pwm, pwm};
    end

    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_pwm_top.sv
// Testbench for pwm_top. Table vectors load one configuration through the
// disabled state and then measure a whole period. Hand-written sequences
// cover reset, a duty change in mid-period, and disabling in mid-period.
module tb_pwm_top;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [7:0] uo_out;

    int vectors;
    int miscompares;

    typedef struct {
        logic [7:0] ui;
        logic [7:0] uio;
        int         period;
        int         exp_high;
        int         exp_dir;
    } vec_t;

    vec_t vecs[9];

    pwm_top dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .uo_out  (uo_out)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Sample for n clocks and accumulate the pwm-high, strobe and dir-down counts.
    // Also count cycles where the complement output or the constant outputs are wrong.
    task automatic measure(input int n, output int high, output int strobes,
                           output int downs, output int cerr, output int zerr);
        high = 0; strobes = 0; downs = 0; cerr = 0; zerr = 0;
        #1;
        for (int i = 0; i < n; i++) begin
            high    += int'(uo_out[0]);
            strobes += int'(uo_out[2]);
            downs   += int'(uo_out[3]);
            if (uo_out[1] != ~uo_out[0]) cerr++;
            if ((uio_out != 8'h00) || (uio_oe != 8'h00)) zerr++;
            step();
        end
    endtask

    // Load a configuration while disabled, so the counters sit at 0 and the shadows are loaded.
    task automatic load_cfg(input logic [7:0] d, input logic [7:0] cfg);
        ui_in  = d;
        uio_in = cfg & 8'h7F;
        step();
        step();
        uio_in = cfg;
    endtask

    initial begin
        int h, s, dn, ce, ze, h2;
        vectors = 0;
        miscompares = 0;

        vecs[0] = '{8'd0,   8'h80, 256,  0,   0};
        vecs[1] = '{8'd255, 8'h80, 256,  255, 0};
        vecs[2] = '{8'd64,  8'h80, 256,  64,  0};
        vecs[3] = '{8'd100, 8'hC0, 512,  200, 256};
        vecs[4] = '{8'd128, 8'h82, 1024, 512, 0};
        vecs[5] = '{8'd64,  8'h90, 256,  192, 0};
        vecs[6] = '{8'd0,   8'hC0, 512,  0,   256};
        vecs[7] = '{8'd255, 8'hC0, 512,  510, 256};
        vecs[8] = '{8'd1,   8'h91, 512,  510, 0};

        // Reset with enable set and D = 64.
        ena    = 1'b1;
        rst_n  = 1'b0;
        ui_in  = 8'd64;
        uio_in = 8'h80;
        step();
        step();
        check("reset_uo_out", int'(uo_out), 32'h06);
        check("reset_uio_out", int'(uio_out), 0);
        check("reset_uio_oe", int'(uio_oe), 0);
        rst_n = 1'b1;
        measure(256, h, s, dn, ce, ze);
        check("reset_first_high", h, 0);
        check("reset_first_strobe", s, 1);
        measure(256, h, s, dn, ce, ze);
        check("reset_second_high", h, 64);
        check("reset_second_strobe", s, 1);

        // Table vectors
        for (int i = 0; i < 9; i++) begin
            load_cfg(vecs[i].ui, vecs[i].uio);
            measure(vecs[i].period, h, s, dn, ce, ze);
            check($sformatf("v%0d_high", i), h, vecs[i].exp_high);
            check($sformatf("v%0d_strobe", i), s, 1);
            check($sformatf("v%0d_dir", i), dn, vecs[i].exp_dir);
            check($sformatf("v%0d_compl", i), ce, 0);
            check($sformatf("v%0d_uio_zero", i), ze, 0);
        end

        // Duty change in mid-period under invert: the new duty waits for the wrap.
        load_cfg(8'd64, 8'h90);
        measure(100, h, s, dn, ce, ze);
        ui_in = 8'd200;
        measure(156, h2, s, dn, ce, ze);
        check("midchg_old_period", h + h2, 192);
        measure(256, h, s, dn, ce, ze);
        check("midchg_new_period", h, 56);

        // Disable in mid-period.
        load_cfg(8'd64, 8'h80);
        measure(40, h, s, dn, ce, ze);
        check("dis_cnt_hi_before", int'(uo_out[7:4]), 2);
        check("dis_pwm_before", int'(uo_out[0]), 1);
        uio_in = 8'h10;
        #1;
        check("dis_pwm_immediate", int'(uo_out[0]), 0);
        step();
        check("dis_uo_out_after_clk", int'(uo_out), 32'h01);
        ui_in  = 8'd10;
        uio_in = 8'h00;
        step();
        uio_in = 8'h80;
        measure(256, h, s, dn, ce, ze);
        check("reen_high", h, 10);
        check("reen_strobe", s, 1);
        check("reen_uio_zero", ze, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_top.md
Name: pwm_top

Overview:
- Configurable 8-bit PWM generator in the standard tile wrapper: dedicated inputs set the duty cycle, bidirectional pins (all inputs) set prescaler, polarity, alignment mode and enable.
- Drives a PWM output, its complement, a period-start strobe and counter status.
- Duty and configuration are double-buffered and take effect only at a period boundary, so the output never glitches.

Parameters:
- none (all widths fixed: 8-bit counter, 4-bit prescale exponent, 15-bit prescale counter)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  tile-selected indication; ignored
- ui_in  in  8  requested duty value D (0..255)
- uio_in  in  8  [3:0] prescale exponent N; [4] invert; [5] reserved, ignored; [6] mode (0 edge, 1 center); [7] enable
- uio_out  out  8  constant 0
- uio_oe  out  8  constant 0 (all bidirectional pins are inputs)
- uo_out  out  8  [0] pwm; [1] ~pwm; [2] period-start strobe; [3] dir (1 = counting down); [7:4] cnt[7:4]

Behaviour:
- State registers: cnt[7:0], dir, pcnt[14:0], and shadows duty_sh[7:0], n_sh[3:0], inv_sh, mode_sh.
- Reset: all state registers cleared to 0 (dir = up).
- Prescaler: tick = (pcnt == 2^n_sh - 1). On tick, pcnt <= 0; otherwise pcnt <= pcnt + 1. N = 0 gives a tick every clock.
- Boundary: a tick while (mode_sh = 0 and cnt = 255), or while (mode_sh = 1 and dir = down and cnt = 0).
  - Sets cnt <= 0, dir <= up.
  - Loads duty_sh <= ui_in, n_sh <= uio_in[3:0], inv_sh <= uio_in[4], mode_sh <= uio_in[6].
- Edge mode, non-boundary tick: cnt <= cnt + 1. Period = 256 ticks.
- Center mode, non-boundary tick:
  - up and cnt < 255: cnt + 1
  - up and cnt = 255: dir <= down, cnt holds
  - down: cnt - 1
  - Sequence is 0..255, 255..0; period = 512 ticks.
- Disabled (uio_in[7] = 0):
  - cnt, dir, pcnt held at 0 / up.
  - All shadows load from inputs every clock.
- Output logic, combinational from registers and the enable input:
  - raw = enable & (cnt < duty_sh)
  - uo_out[0] = raw ^ inv_sh
  - uo_out[1] = ~uo_out[0]
- Duty boundaries:
  - D = 0: raw is always 0.
  - Edge mode, D = 255: raw is 0 for exactly one tick per period.
  - Center mode: high time = 2·D ticks per 512.
- uo_out[2] = enable & (cnt == 0) & (dir == up) & (pcnt == 0). This is one clock per period at the period start.
- Changing inputs mid-period has no effect until the next boundary, or until the next clock while disabled.
- Switching mode at a boundary always starts the new period at cnt = 0, dir = up.
- Reset mid-period: immediate asynchronous return to reset state. After reset release, pwm = 0 until the first boundary (duty_sh = 0), unless disabled, in which case shadows load on the next clock.

Test Plan:
- Reset with uio_in = 0x80, ui_in = 64 → uo_out[0] = 0, uo_out[1] = 1 during reset. First period after release has duty 0. From the second period on, pwm is high 64 clocks and low 192, and uo_out[2] pulses once every 256 clocks.
- Edge, N = 0: D = 0 → pwm never high. D = 255 → pwm low exactly 1 clock per 256.
- Center mode (uio_in = 0xC0), D = 100 → period 512 clocks, pwm high 200 clocks split 100 at the start and 100 at the end. uo_out[3] = 1 for cnt sequence 255..0 on the down leg.
- Prescale N = 2, edge, D = 128 → period 1024 clocks, high 512, uo_out[2] width 1 clock.
- Invert: uio_in[4] = 1, D = 64 → pwm low 64 / high 192. Changing ui_in to 200 mid-period takes effect only at the next cnt wrap.
- Disable mid-period (uio_in[7] = 0) → pwm = inv_sh immediately, cnt = 0, uo_out[7:4] = 0. Re-enable → new period starts with the current ui_in duty. uio_out = uio_oe = 0 throughout.
